// File: rtl/stream_packetizer.sv
// rtl/stream_packetizer.sv - fixed-length packet framer from a show-ahead FIFO onto a ready/valid sink
// Optional feature macro: STREAM_PKT_CNT_EN adds the pkt_count port and its completed-packet counter.
module stream_packetizer #(
  parameter int DATA_W  = 32,
  parameter int PKT_LEN = 4,
  parameter int GAP     = 1,
  parameter int LVL_W   = 8
`ifdef STREAM_PKT_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk_hifreq,
  input  logic              rst,
  input  logic              en,
  input  logic [LVL_W-1:0]  fifo_level,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  input  logic              out_rdy,
  output logic              busy
`ifdef STREAM_PKT_CNT_EN
  , output logic [CNT_W-1:0] pkt_count
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Last beat index and last gap index, truncated to the counter widths.
  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);
  localparam logic [7:0]  GAP_LAST  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam bit          HAS_GAP   = (GAP > 0);
  // Compared at 32 bits so a PKT_LEN wider than fifo_level can never be met.
  localparam logic [31:0] PKT_LEN_U = 32'(PKT_LEN);

  logic [1:0]  state_q, state_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [31:0] level_ext;
  logic        start;
  logic        xfer;
  logic        last_beat;

  assign level_ext = 32'(fifo_level);
  assign start     = en && (level_ext >= PKT_LEN_U);
  assign last_beat = (beat_cnt_q == LAST_BEAT);

  // Sink-side handshake and framing, all derived from registered state.
  always_comb begin
    out_valid  = (state_q == ST_SEND) && en && !fifo_empty;
    xfer       = out_valid && out_rdy;
    fifo_rd_en = xfer;
    out_sop    = out_valid && (beat_cnt_q == 16'd0);
    out_eop    = out_valid && last_beat;
    busy       = (state_q != ST_IDLE);
    out_data   = fifo_rd_data;
  end

  // Next-state and counter updates; everything holds while en is low.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_SEND;
            beat_cnt_d = 16'd0;
          end
        end
        ST_SEND: begin
          if (xfer) begin
            if (last_beat) begin
              beat_cnt_d = 16'd0;
              if (HAS_GAP) begin
                state_d   = ST_GAP;
                gap_cnt_d = 8'd0;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              beat_cnt_d = beat_cnt_q + 16'd1;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d   = ST_IDLE;
            gap_cnt_d = 8'd0;
          end else begin
            gap_cnt_d = gap_cnt_q + 8'd1;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          beat_cnt_d = 16'd0;
          gap_cnt_d  = 8'd0;
        end
      endcase
    end
  end

  // State and counter registers; reset truncates any packet in flight.
  always_ff @(posedge clk_hifreq) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= 16'd0;
      gap_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

`ifdef STREAM_PKT_CNT_EN
  logic [CNT_W-1:0] pkt_count_q;

  // Completed-packet counter, bumped on every eop transfer and wrapping.
  always_ff @(posedge clk_hifreq) begin
    if (rst) begin
      pkt_count_q <= '0;
    end else if (xfer && out_eop) begin
      pkt_count_q <= pkt_count_q + 1'b1;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule
